// File: rtl/acq_scheduler_if.sv
// Signal bundle between the host config port, the AD7606 controller and the
// acquisition scheduler. The scheduler side uses the slave modport.
interface acq_scheduler_if #(
  parameter int PERIOD_NBIT = 16,
  parameter int CNT_NBIT    = 16,
  parameter int CHN_NUM     = 8
);
  localparam int CHN_W = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1;

  logic                   cfg_start;
  logic                   cfg_stop;
  logic [PERIOD_NBIT-1:0] cfg_period;
  logic [CNT_NBIT-1:0]    cfg_nsamples;
  logic [CHN_NUM-1:0]     cfg_chmask;
  logic                   conv_req;
  logic                   ad_vd;
  logic [CHN_W-1:0]       ad_chn;
  logic                   cache_wr;
  logic                   busy;
  logic                   done;
  logic                   overrun;
  logic                   timeout;
  logic [CNT_NBIT-1:0]    sample_cnt;

  modport master (
    output cfg_start, cfg_stop, cfg_period, cfg_nsamples, cfg_chmask, ad_vd,
    input  conv_req, ad_chn, cache_wr, busy, done, overrun, timeout, sample_cnt
  );

  modport slave (
    input  cfg_start, cfg_stop, cfg_period, cfg_nsamples, cfg_chmask, ad_vd,
    output conv_req, ad_chn, cache_wr, busy, done, overrun, timeout, sample_cnt
  );
endinterface

// File: rtl/acq_scheduler.sv
// Paces AD7606 conversions on a free-running period timer and, after each
// conversion, writes the enabled channels into the sample cache one per cycle.
module acq_scheduler #(
  parameter int PERIOD_NBIT  = 16,
  parameter int CNT_NBIT     = 16,
  parameter int CHN_NUM      = 8,
  parameter int CONV_TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  acq_scheduler_if.slave bus
);
  localparam int CHN_W = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1;
  localparam int TO_W  = $clog2(CONV_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_TICK, CONV, SCAN} state_t;

  state_t                 state, state_nxt;
  logic                   busy, busy_nxt;
  logic                   conv_req, conv_req_nxt;
  logic                   cache_wr, cache_wr_nxt;
  logic                   done, done_nxt;
  logic                   overrun, overrun_nxt;
  logic                   timeout, timeout_nxt;
  logic [CHN_W-1:0]       chn, chn_nxt;
  logic [CNT_NBIT-1:0]    cnt, cnt_nxt;
  logic [PERIOD_NBIT-1:0] period_q, period_nxt;
  logic [PERIOD_NBIT-1:0] tmr, tmr_nxt;
  logic [CNT_NBIT-1:0]    nsamples_q, nsamples_nxt;
  logic [CHN_NUM-1:0]     chmask_q, chmask_nxt;
  logic [CHN_NUM-1:0]     pend, pend_nxt;
  logic [TO_W-1:0]        to_cnt, to_nxt;
  logic                   tick;

  function automatic logic [CHN_W-1:0] first_chn(input logic [CHN_NUM-1:0] m);
    first_chn = '0;
    for (int i = CHN_NUM - 1; i >= 0; i--)
      if (m[i]) first_chn = CHN_W'(i);
  endfunction

  // Timer restarts at zero on start, so the first tick lands on the first WAIT_TICK cycle.
  assign tick = busy && (tmr == '0);

  always_comb begin
    state_nxt    = state;
    busy_nxt     = busy;
    conv_req_nxt = 1'b0;
    cache_wr_nxt = 1'b0;
    done_nxt     = 1'b0;
    overrun_nxt  = overrun;
    timeout_nxt  = timeout;
    chn_nxt      = chn;
    cnt_nxt      = cnt;
    period_nxt   = period_q;
    nsamples_nxt = nsamples_q;
    chmask_nxt   = chmask_q;
    pend_nxt     = pend;
    tmr_nxt      = '0;
    to_nxt       = '0;

    if (busy)
      tmr_nxt = (tmr == period_q - PERIOD_NBIT'(1)) ? '0 : tmr + PERIOD_NBIT'(1);
    if (tick && (state == CONV || state == SCAN))
      overrun_nxt = 1'b1;

    if (state != IDLE && bus.cfg_stop) begin
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cfg_start && !bus.cfg_stop) begin
            period_nxt   = (bus.cfg_period < PERIOD_NBIT'(2)) ? PERIOD_NBIT'(2) : bus.cfg_period;
            nsamples_nxt = bus.cfg_nsamples;
            chmask_nxt   = bus.cfg_chmask;
            cnt_nxt      = '0;
            overrun_nxt  = 1'b0;
            timeout_nxt  = 1'b0;
            busy_nxt     = 1'b1;
            state_nxt    = WAIT_TICK;
          end
        end
        WAIT_TICK: begin
          if (tick) begin
            conv_req_nxt = 1'b1;
            state_nxt    = CONV;
          end
        end
        CONV: begin
          // The first write is registered here so it appears the cycle after ad_vd.
          if (bus.ad_vd) begin
            state_nxt = SCAN;
            pend_nxt  = chmask_q;
            if (chmask_q != '0) begin
              cache_wr_nxt = 1'b1;
              chn_nxt      = first_chn(chmask_q);
              pend_nxt     = chmask_q & (chmask_q - CHN_NUM'(1));
            end
          end else if (to_cnt == TO_W'(CONV_TIMEOUT - 1)) begin
            timeout_nxt = 1'b1;
            state_nxt   = WAIT_TICK;
          end else begin
            to_nxt = to_cnt + TO_W'(1);
          end
        end
        SCAN: begin
          if (pend != '0) begin
            cache_wr_nxt = 1'b1;
            chn_nxt      = first_chn(pend);
            pend_nxt     = pend & (pend - CHN_NUM'(1));
          end else if (nsamples_q == '0) begin
            if (cnt != '1) cnt_nxt = cnt + CNT_NBIT'(1);
            state_nxt = WAIT_TICK;
          end else if (cnt + CNT_NBIT'(1) == nsamples_q) begin
            cnt_nxt   = cnt + CNT_NBIT'(1);
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = cnt + CNT_NBIT'(1);
            state_nxt = WAIT_TICK;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      conv_req <= 1'b0;
      cache_wr <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
      chn      <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= busy_nxt;
      conv_req <= conv_req_nxt;
      cache_wr <= cache_wr_nxt;
      done     <= done_nxt;
      overrun  <= overrun_nxt;
      timeout  <= timeout_nxt;
      chn      <= chn_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Burst configuration and scan bookkeeping; only meaningful while busy.
  always_ff @(posedge clk) begin
    period_q   <= period_nxt;
    nsamples_q <= nsamples_nxt;
    chmask_q   <= chmask_nxt;
    pend       <= pend_nxt;
    tmr        <= tmr_nxt;
    to_cnt     <= to_nxt;
  end

  assign bus.conv_req   = conv_req;
  assign bus.cache_wr   = cache_wr;
  assign bus.ad_chn     = chn;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.overrun    = overrun;
  assign bus.timeout    = timeout;
  assign bus.sample_cnt = cnt;
endmodule

// File: tb/tb_acq_scheduler.sv
// Directed bench for acq_scheduler: table of burst configurations plus
// hand-written timeout, stop, and asynchronous reset sequences.
module tb_acq_scheduler;
  localparam int PERIOD_NBIT  = 16;
  localparam int CNT_NBIT     = 16;
  localparam int CHN_NUM      = 8;
  localparam int CONV_TIMEOUT = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  acq_scheduler_if #(.PERIOD_NBIT(PERIOD_NBIT), .CNT_NBIT(CNT_NBIT), .CHN_NUM(CHN_NUM)) bus ();

  acq_scheduler #(
    .PERIOD_NBIT(PERIOD_NBIT), .CNT_NBIT(CNT_NBIT),
    .CHN_NUM(CHN_NUM), .CONV_TIMEOUT(CONV_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period; int nsamples; int chmask; int vd_dly; int run;
    int conv; int gap; int wr; int cnt; int done; int ovr; int busy;
  } vec_t;

  int cyc = 0;
  int vd_dly = -1;
  int vd_at = -1;
  int conv_cyc[$];
  int wr_q[$];
  int done_n = 0;
  int total = 0;
  int bad = 0;

  // Model of the AD7606 controller: ad_vd a fixed number of cycles after conv_req.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1 bus.ad_vd = (cyc == vd_at);
  end

  always @(negedge clk) begin
    if (bus.conv_req === 1'b1) begin
      conv_cyc.push_back(cyc);
      if (vd_dly > 0) vd_at = cyc + vd_dly;
    end
    if (bus.cache_wr === 1'b1) wr_q.push_back(int'(bus.ad_chn));
    if (bus.done === 1'b1) done_n++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    conv_cyc.delete();
    wr_q.delete();
    done_n = 0;
    vd_at  = -1;
  endtask

  task automatic setup(input int period, input int nsamples, input int chmask, input int dly);
    bus.cfg_period   = PERIOD_NBIT'(period);
    bus.cfg_nsamples = CNT_NBIT'(nsamples);
    bus.cfg_chmask   = CHN_NUM'(chmask);
    vd_dly = dly;
  endtask

  task automatic stop_and_idle();
    bus.cfg_stop = 1'b1;
    step(1);
    bus.cfg_stop = 1'b0;
    step(4);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int exp_q[$];
    int mism;
    int gap;
    int first;
    int t0;
    clear_mon();
    setup(v.period, v.nsamples, v.chmask, v.vd_dly);
    t0 = cyc;
    bus.cfg_start = 1'b1;
    step(1);
    bus.cfg_start = 1'b0;
    chk($sformatf("v%0d_busy_rise", idx), bus.busy, 1);
    step(v.run - 1);
    chk($sformatf("v%0d_busy_end", idx), bus.busy, v.busy);
    stop_and_idle();
    first = (conv_cyc.size() > 0) ? conv_cyc[0] - t0 : -1;
    gap   = (conv_cyc.size() >= 2) ? conv_cyc[1] - conv_cyc[0] : 0;
    chk($sformatf("v%0d_first_conv", idx), first, 2);
    chk($sformatf("v%0d_conv_n", idx), conv_cyc.size(), v.conv);
    chk($sformatf("v%0d_conv_gap", idx), gap, v.gap);
    chk($sformatf("v%0d_wr_n", idx), wr_q.size(), v.wr);
    chk($sformatf("v%0d_cnt", idx), bus.sample_cnt, v.cnt);
    chk($sformatf("v%0d_done_n", idx), done_n, v.done);
    chk($sformatf("v%0d_overrun", idx), bus.overrun, v.ovr);
    for (int s = 0; s < v.cnt; s++)
      for (int c = 0; c < CHN_NUM; c++)
        if (v.chmask[c]) exp_q.push_back(c);
    mism = (wr_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      if (wr_q[i] != exp_q[i]) mism++;
    chk($sformatf("v%0d_wr_order", idx), mism, 0);
  endtask

  vec_t vecs[5];

  initial begin
    int t0;
    //           per ns  mask  dly run  conv gap  wr cnt done ovr busy
    vecs[0] = '{10,  3, 'h05,  4, 60,   3,  10,  6,  3,  1,  0,  0};
    vecs[1] = '{ 5,  1, 'h80,  1, 20,   1,   0,  1,  1,  1,  0,  0};
    vecs[2] = '{ 3,  2, 'hFF,  4, 60,   2,  15, 16,  2,  1,  1,  0};
    vecs[3] = '{ 0,  0, 'h00,  2, 30,   5,   6,  0,  5,  0,  1,  1};
    vecs[4] = '{ 0,  0, 'h00,  1, 40,  10,   4,  0,  9,  0,  1,  1};

    bus.cfg_start = 1'b0;
    bus.cfg_stop  = 1'b0;
    bus.ad_vd     = 1'b0;
    setup(0, 0, 0, -1);

    step(3);
    chk("rst_flags", {bus.conv_req, bus.cache_wr, bus.busy, bus.done, bus.overrun, bus.timeout}, 0);
    chk("rst_cnt", bus.sample_cnt, 0);
    chk("rst_chn", bus.ad_chn, 0);
    rst_n = 1'b1;
    step(2);
    chk("idle_flags", {bus.conv_req, bus.cache_wr, bus.busy, bus.done, bus.overrun, bus.timeout}, 0);

    // start and stop together in IDLE do nothing
    setup(4, 1, 1, 1);
    bus.cfg_start = 1'b1;
    bus.cfg_stop  = 1'b1;
    step(1);
    bus.cfg_start = 1'b0;
    bus.cfg_stop  = 1'b0;
    chk("startstop_busy", bus.busy, 0);
    step(1);
    chk("startstop_conv", bus.conv_req, 0);
    step(3);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // conversion timeout with no ad_vd
    clear_mon();
    setup(1100, 0, 'h01, -1);
    t0 = cyc;
    bus.cfg_start = 1'b1;
    step(1);
    bus.cfg_start = 1'b0;
    step(1024);
    chk("to_before", bus.timeout, 0);
    step(1);
    chk("to_at", bus.timeout, 1);
    chk("to_cnt", bus.sample_cnt, 0);
    chk("to_ovr_cleared", bus.overrun, 0);
    chk("to_busy", bus.busy, 1);
    step(80);
    chk("to_first", (conv_cyc.size() > 0) ? conv_cyc[0] - t0 : -1, 2);
    chk("to_conv_n", conv_cyc.size(), 2);
    chk("to_gap", (conv_cyc.size() >= 2) ? conv_cyc[1] - conv_cyc[0] : 0, 1100);
    stop_and_idle();
    chk("to_sticky", bus.timeout, 1);
    chk("to_stop_busy", bus.busy, 0);

    // stop during SCAN after the 2nd of 4 writes
    clear_mon();
    setup(20, 5, 'h0F, 2);
    bus.cfg_start = 1'b1;
    step(1);
    bus.cfg_start = 1'b0;
    chk("st_to_cleared", bus.timeout, 0);
    step(14);
    bus.cfg_start = 1'b1;
    step(1);
    bus.cfg_start = 1'b0;
    step(10);
    chk("st_wr2", {bus.cache_wr, bus.ad_chn}, {1'b1, 3'd1});
    bus.cfg_stop = 1'b1;
    step(1);
    bus.cfg_stop = 1'b0;
    chk("st_busy", bus.busy, 0);
    chk("st_nowr", bus.cache_wr, 0);
    step(5);
    chk("st_wr_n", wr_q.size(), 6);
    chk("st_done", done_n, 0);
    chk("st_cnt", bus.sample_cnt, 1);

    // asynchronous reset during CONV of the second conversion
    clear_mon();
    setup(10, 0, 'h01, 3);
    bus.cfg_start = 1'b1;
    step(1);
    bus.cfg_start = 1'b0;
    step(12);
    chk("ar_pre_busy", bus.busy, 1);
    chk("ar_pre_cnt", bus.sample_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_flags", {bus.conv_req, bus.cache_wr, bus.busy, bus.done, bus.overrun, bus.timeout}, 0);
    chk("ar_cnt", bus.sample_cnt, 0);
    chk("ar_chn", bus.ad_chn, 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("ar_no_done", done_n, 0);
    clear_mon();
    setup(10, 2, 'h01, 3);
    bus.cfg_start = 1'b1;
    step(1);
    bus.cfg_start = 1'b0;
    chk("ar_restart_busy", bus.busy, 1);
    chk("ar_restart_noconv", bus.conv_req, 0);
    step(1);
    chk("ar_restart_conv", bus.conv_req, 1);
    stop_and_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
